freq_mult_ctrl: RTL and testbench

- Sequencing controller for the frequency-multiplier datapath (counter / shifter / divider).
- Drives the datapath's `init`, `en` and `ld` strobes to measure one full period of `InFreq` in `ref_f` cycles.
- Commits the shifted count into the divider, then reports lock.
- Detects missing or too-slow input with a timeout, and supports abort and re-measurement on request.

---
 rtl/freq_mult_ctrl_if.sv | 34 +++
 rtl/freq_mult_ctrl.sv | 128 ++++++++++++
 tb/tb_freq_mult_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_mult_ctrl_if.sv
// Control and strobe bundle between the frequency-multiplier sequencer and
// its user / datapath.
//
// Handshake: start and abort are level-sampled requests with no ready
// signal. start is honoured only when the controller is not busy (IDLE,
// LOCKED, FAULT); abort is honoured in every state and wins over start.
// init, en and ld are single-cycle or windowed strobes toward the datapath.
// busy, locked and fault are mutually exclusive status flags; period is
// meaningful only while locked is high.
interface freq_mult_ctrl_if #(
    parameter int CNT_W = 14
);
    logic             start;
    logic             abort;
    logic             init;
    logic             en;
    logic             ld;
    logic             busy;
    logic             locked;
    logic             fault;
    logic [CNT_W-1:0] period;

    // Requester side: issues start/abort, observes strobes and status.
    modport master (
        output start, abort,
        input  init, en, ld, busy, locked, fault, period
    );

    // Controller side.
    modport slave (
        input  start, abort,
        output init, en, ld, busy, locked, fault, period
    );
endinterface

// File: rtl/freq_mult_ctrl.sv
// Sequencer for the frequency-multiplier datapath: measures one InFreq
// period in ref_f cycles (en window), reloads the divider (ld), reports
// lock, and falls into FAULT if no rising edge arrives within TIMEOUT.
module freq_mult_ctrl #(
    parameter int CNT_W   = 14,
    parameter int TIMEOUT = 8190
) (
    input  logic            ref_f,
    input  logic            rst,
    input  logic            InFreq,
    freq_mult_ctrl_if.slave bus,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ARM     = 3'd2,
        S_MEASURE = 3'd3,
        S_LOAD    = 3'd4,
        S_LOCKED  = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] TC_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TC_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] tc;
    logic [CNT_W-1:0] period_q;
    logic             init_q, en_q, ld_q, busy_q, locked_q, fault_q;

    // Both window edges pass through the same three flops, so the
    // synchronizer latency cancels out of the measured period.
    assign rise = s2 & ~s3;

    // Bring InFreq into the ref_f domain and keep one extra stage for edge detect.
    always_ff @(posedge ref_f) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= InFreq;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Next-state decision; abort beats every other condition.
    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (bus.start) state_nxt = S_CLEAR;
                S_CLEAR:   state_nxt = S_ARM;
                S_ARM: begin
                    if (rise)              state_nxt = S_MEASURE;
                    else if (tc == TC_MAX) state_nxt = S_FAULT;
                end
                S_MEASURE: begin
                    if (rise)              state_nxt = S_LOAD;
                    else if (tc == TC_MAX) state_nxt = S_FAULT;
                end
                S_LOAD:    state_nxt = S_LOCKED;
                S_LOCKED:  if (bus.start) state_nxt = S_CLEAR;
                S_FAULT:   if (bus.start) state_nxt = S_CLEAR;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // State, counter, captured period and Moore outputs decoded from the next state.
    always_ff @(posedge ref_f) begin
        if (rst) begin
            state    <= S_IDLE;
            tc       <= '0;
            period_q <= '0;
            init_q   <= 1'b0;
            en_q     <= 1'b0;
            ld_q     <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state <= state_nxt;

            case (state)
                S_CLEAR: tc <= '0;
                S_ARM: begin
                    if (rise)              tc <= TC_ONE;
                    else if (tc != TC_MAX) tc <= tc + TC_ONE;
                end
                S_MEASURE: begin
                    if (tc != TC_MAX) tc <= tc + TC_ONE;
                end
                default: tc <= tc;
            endcase

            // tc counts the MEASURE cycles so far, which equals the period on the closing rise.
            if (state == S_MEASURE && rise && !bus.abort) begin
                period_q <= tc;
            end

            init_q   <= (state_nxt == S_CLEAR);
            en_q     <= (state_nxt == S_MEASURE);
            ld_q     <= (state_nxt == S_LOAD);
            busy_q   <= (state_nxt inside {S_CLEAR, S_ARM, S_MEASURE, S_LOAD});
            locked_q <= (state_nxt == S_LOCKED);
            fault_q  <= (state_nxt == S_FAULT);
        end
    end

    assign bus.init   = init_q;
    assign bus.en     = en_q;
    assign bus.ld     = ld_q;
    assign bus.busy   = busy_q;
    assign bus.locked = locked_q;
    assign bus.fault  = fault_q;
    assign bus.period = period_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_freq_mult_ctrl.sv
// Bench for freq_mult_ctrl: table-driven and randomized period measurements
// against a period model (high phase + low phase in ref_f cycles), plus
// hand-written timeout, abort and reset sequences.
module tb_freq_mult_ctrl;

    localparam int CNT_W   = 14;
    localparam int TIMEOUT = 8190;

    // ---------------- clock / reset ----------------
    logic       ref_f = 1'b0;
    logic       rst   = 1'b1;
    logic       InFreq;
    logic [2:0] dbg_state;

    always #5 ref_f = ~ref_f;

    freq_mult_ctrl_if #(.CNT_W(CNT_W)) bus ();

    freq_mult_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .ref_f     (ref_f),
        .rst       (rst),
        .InFreq    (InFreq),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int compared   = 0;
    int mismatched = 0;
    logic [CNT_W-1:0] exp_q[$];
    int period_model = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- InFreq generator ----------------
    // mode 0: periodic hi/lo, 1: stuck low, 2: stuck high, 3: follows man_level
    int   gen_hi = 1, gen_lo = 1, gen_mode = 0;
    logic man_level = 1'b0;
    int   prev_total = 2;

    initial begin
        InFreq = 1'b0;
        forever begin
            if (gen_mode == 0) begin
                InFreq = 1'b1;
                repeat (gen_hi) @(negedge ref_f);
                InFreq = 1'b0;
                repeat (gen_lo) @(negedge ref_f);
            end else if (gen_mode == 3) begin
                InFreq = man_level;
                @(man_level or gen_mode);
            end else begin
                InFreq = (gen_mode == 2);
                @(negedge ref_f);
            end
        end
    end

    // ---------------- strobe monitor ----------------
    int   init_cnt = 0, ld_cnt = 0, en_starts = 0;
    int   en_run = 0, last_en_run = 0;
    logic ld_after_en = 1'b0;
    logic prev_en = 1'b0;

    initial begin
        forever begin
            @(negedge ref_f);
            if (bus.init || bus.en || bus.ld)
                check("strobe_exclusive", int'(bus.init) + int'(bus.en) + int'(bus.ld), 1);
            if (bus.init) init_cnt++;
            if (bus.ld)   ld_cnt++;
            if (bus.en) begin
                if (!prev_en) en_starts++;
                en_run++;
            end else if (prev_en) begin
                last_en_run = en_run;
                ld_after_en = bus.ld;
                en_run      = 0;
            end
            prev_en = bus.en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge ref_f);
        bus.start = 1'b1;
        @(negedge ref_f);
        bus.start = 1'b0;
    endtask

    task automatic do_measure(input int hi, input int lo, input int exp_period);
        int i0, l0, n;
        logic [CNT_W-1:0] exp_p;
        gen_mode = 0;
        gen_hi   = hi;
        gen_lo   = lo;
        repeat (prev_total + 2 * (hi + lo) + 8) @(negedge ref_f);
        prev_total = hi + lo;
        i0 = init_cnt;
        l0 = ld_cnt;
        exp_q.push_back(CNT_W'(exp_period));
        pulse_start();
        check("start_init", int'(bus.init), 1);
        check("start_busy", int'(bus.busy), 1);
        check("start_locked_drop", int'(bus.locked), 0);
        n = 0;
        while (!bus.locked && !bus.fault && n < 3 * TIMEOUT) begin
            @(negedge ref_f);
            n++;
        end
        exp_p = exp_q.pop_front();
        check("meas_locked", int'(bus.locked), 1);
        check("meas_period", int'(bus.period), int'(exp_p));
        check("meas_en_len", last_en_run, int'(exp_p));
        check("meas_ld_follows_en", int'(ld_after_en), 1);
        check("meas_init_pulses", init_cnt - i0, 1);
        check("meas_ld_pulses", ld_cnt - l0, 1);
        period_model = exp_period;
    endtask

    typedef struct {
        int hi;
        int lo;
        int exp_period;
    } vec_t;

    vec_t vecs[6];

    // ---------------- main sequence ----------------
    initial begin
        int n, e0, l0, hi, lo;
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // Reset with InFreq toggling every cycle.
        rst      = 1'b1;
        gen_mode = 0;
        repeat (2) @(negedge ref_f);
        check("rst_state", int'(dbg_state), 0);
        check("rst_outputs", {28'd0, bus.init, bus.en, bus.ld, bus.busy}, 0);
        check("rst_status", {30'd0, bus.locked, bus.fault}, 0);
        check("rst_period", int'(bus.period), 0);
        rst = 1'b0;
        repeat (20) @(negedge ref_f);
        check("idle_no_strobes", init_cnt + ld_cnt + en_starts, 0);
        check("idle_state", int'(dbg_state), 0);

        // Table of measurements; 100 then 37 exercises re-measure from LOCKED.
        vecs[0] = '{50, 50, 100};
        vecs[1] = '{18, 19, 37};
        vecs[2] = '{1, 1, 2};
        vecs[3] = '{5, 1, 6};
        vecs[4] = '{1, 7, 8};
        vecs[5] = '{200, 57, 257};
        for (int i = 0; i < 6; i++) begin
            do_measure(vecs[i].hi, vecs[i].lo, vecs[i].exp_period);
        end

        // Randomized periods against the hi+lo model.
        for (int i = 0; i < 8; i++) begin
            hi = $urandom_range(1, 150);
            lo = $urandom_range(1, 150);
            do_measure(hi, lo, hi + lo);
        end

        // start and abort together in LOCKED: abort wins.
        @(negedge ref_f);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge ref_f);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_locked_state", int'(dbg_state), 0);
        check("abort_locked_flags", {29'd0, bus.busy, bus.locked, bus.init}, 0);
        check("abort_locked_period", int'(bus.period), period_model);

        // InFreq stuck low: FAULT after CLEAR + TIMEOUT+1 ARM cycles.
        gen_mode = 1;
        repeat (prev_total + 8) @(negedge ref_f);
        e0 = en_starts;
        pulse_start();
        check("to_arm_not_yet", int'(bus.fault), 0);
        n = 0;
        while (!bus.fault && n < 2 * TIMEOUT) begin
            @(negedge ref_f);
            n++;
        end
        check("to_arm_cycles", n, TIMEOUT + 2);
        check("to_arm_no_en", en_starts - e0, 0);
        check("to_arm_period", int'(bus.period), period_model);
        repeat (20) @(negedge ref_f);
        check("to_arm_fault_held", {30'd0, bus.fault, bus.busy}, 2);

        // One rise then stuck high: FAULT from MEASURE after TIMEOUT en cycles.
        l0 = ld_cnt;
        pulse_start();
        repeat (5) @(negedge ref_f);
        gen_mode = 2;
        n = 0;
        while (!bus.fault && n < 2 * TIMEOUT + 100) begin
            @(negedge ref_f);
            n++;
        end
        check("to_meas_fault", int'(bus.fault), 1);
        check("to_meas_en_len", last_en_run, TIMEOUT);
        check("to_meas_no_ld", ld_cnt - l0, 0);
        check("to_meas_period", int'(bus.period), period_model);

        // Abort in MEASURE on the very cycle a rise is seen.
        man_level = 1'b0;
        gen_mode  = 3;
        repeat (6) @(negedge ref_f);
        pulse_start();
        repeat (4) @(negedge ref_f);
        man_level = 1'b1;
        @(negedge ref_f);
        @(negedge ref_f);
        check("sync_latency_early", int'(bus.en), 0);
        @(negedge ref_f);
        check("sync_latency_en", int'(bus.en), 1);
        repeat (3) @(negedge ref_f);
        man_level = 1'b0;
        repeat (4) @(negedge ref_f);
        l0 = ld_cnt;
        man_level = 1'b1;
        @(negedge ref_f);
        @(negedge ref_f);
        bus.abort = 1'b1;
        @(negedge ref_f);
        bus.abort = 1'b0;
        check("abort_meas_state", int'(dbg_state), 0);
        check("abort_meas_en", int'(bus.en), 0);
        check("abort_meas_busy", int'(bus.busy), 0);
        check("abort_meas_period", int'(bus.period), period_model);
        repeat (10) @(negedge ref_f);
        check("abort_meas_no_ld", ld_cnt - l0, 0);

        // Reset in the LOAD cycle clears everything including period.
        gen_mode = 0;
        gen_hi   = 10;
        gen_lo   = 10;
        repeat (50) @(negedge ref_f);
        pulse_start();
        n = 0;
        while (!bus.ld && n < 3 * TIMEOUT) begin
            @(negedge ref_f);
            n++;
        end
        check("load_reached", int'(bus.ld), 1);
        rst = 1'b1;
        @(negedge ref_f);
        rst = 1'b0;
        period_model = 0;
        check("rst_load_state", int'(dbg_state), 0);
        check("rst_load_outputs", {26'd0, bus.init, bus.en, bus.ld, bus.busy, bus.locked, bus.fault}, 0);
        check("rst_load_period", int'(bus.period), period_model);
        repeat (30) @(negedge ref_f);
        check("rst_load_stays_idle", int'(dbg_state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
